// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the multicycle instruction-fetch sequencer.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_REQ     = 3'd2,
    S_WAIT    = 3'd3,
    S_LOAD_IR = 3'd4,
    S_EXEC    = 3'd5,
    S_HALT    = 3'd6
  } fetch_state_t;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_BUS      = 2'd2,
    FAULT_TIMEOUT  = 2'd3
  } fault_cause_t;

  function automatic logic state_busy(fetch_state_t s);
    return !(s inside {S_IDLE, S_HALT});
  endfunction

endpackage

// File: rtl/fetch_sequencer_wait_timer.sv
// Response wait counter: clear on request handshake, count no-response cycles,
// saturate instead of wrapping, flag the cycle that reaches TIMEOUT.
module wait_timer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // Count value during the TIMEOUT-th waiting cycle (first cycle sees zero).
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en && cnt != CNT_MAX)
      cnt <= cnt + 1'b1;
  end

  // Caller qualifies with "no response this cycle"; kept free of en to avoid
  // a combinational path back into the FSM's decode.
  assign expired = (TIMEOUT != 0) && (cnt == CNT_LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// Multicycle fetch controller: PC->MAR, memory read, MDR->IR, hand to execute,
// then advance or redirect PC. Faults park the FSM in HALT until reset.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pc_misaligned,
  output logic       mem_req_valid,
  input  logic       mem_req_ready,
  input  logic       mem_rsp_valid,
  input  logic       mem_rsp_err,
  output logic       mar_load,
  output logic       mdr_load,
  output logic       ir_load,
  output logic       pc_load,
  output logic       pc_sel,
  output logic       instr_valid,
  input  logic       exec_done,
  input  logic       redirect,
  output logic       busy,
  output logic       fault,
  output logic [1:0] fault_cause
);

  fetch_state_t state, state_nxt;
  fault_cause_t cause_q, cause_nxt;
  logic         tmr_clr, tmr_en, tmr_expired;

  wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cause_q <= FAULT_NONE;
    end else begin
      state   <= state_nxt;
      cause_q <= cause_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cause_nxt = cause_q;
    mar_load  = 1'b0;
    mdr_load  = 1'b0;
    pc_load   = 1'b0;
    pc_sel    = 1'b0;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_ADDR;
      S_ADDR: begin
        if (pc_misaligned) begin
          cause_nxt = FAULT_MISALIGN;
          state_nxt = S_HALT;
        end else begin
          mar_load  = 1'b1;
          state_nxt = S_REQ;
        end
      end
      // start is deliberately not sampled here: an issued request completes.
      S_REQ: begin
        if (mem_req_ready) begin
          tmr_clr   = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          if (mem_rsp_err) begin
            cause_nxt = FAULT_BUS;
            state_nxt = S_HALT;
          end else begin
            mdr_load  = 1'b1;
            state_nxt = S_LOAD_IR;
          end
        end else begin
          tmr_en = 1'b1;
          if (tmr_expired) begin
            cause_nxt = FAULT_TIMEOUT;
            state_nxt = S_HALT;
          end
        end
      end
      S_LOAD_IR: state_nxt = S_EXEC;
      S_EXEC: begin
        if (exec_done) begin
          pc_load   = 1'b1;
          pc_sel    = redirect;
          state_nxt = start ? S_ADDR : S_IDLE;
        end
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign mem_req_valid = (state == S_REQ);
  assign ir_load       = (state == S_LOAD_IR);
  assign instr_valid   = (state == S_EXEC);
  assign fault         = (state == S_HALT);
  assign busy          = state_busy(state);
  assign fault_cause   = cause_q;

endmodule
